// File: rtl/pipe_pkg.sv
// Shared constants and tag types for the five-stage pipeline hazard logic.
// Forward-select encodings and the default-width stage tag live here.
package pipe_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] dst;
    logic                  load;
  } tag_t;

  // Youngest producer wins: EX first, then MEM.
  function automatic logic [1:0] fwd_pick(
    input logic ex_hit,
    input logic mem_hit
  );
    if (ex_hit)
      return FWD_EXMEM;
    else if (mem_hit)
      return FWD_MEMWB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_tag_stage.sv
// One pipeline tag register with bubble insertion.
// A bubble clears the whole tag, so its valid bit reads 0.
module pipe_tag_stage
  import pipe_pkg::*;
#(
  parameter int W = $bits(tag_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         bubble,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= '0;
    else if (bubble)
      q <= '0;
    else
      q <= d;
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding control beside the ID stage.
// Define HAZ_FWD_EN to enable EX/MEM forwarding; otherwise RAW hazards stall.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              load;
  } htag_t;

  localparam int TW = $bits(htag_t);

  htag_t id_tag;
  htag_t ex_q;
  htag_t mem_q;
  htag_t wb_q;
  logic  ex_bubble;

  function automatic logic hit(
    input htag_t             t,
    input logic              use_s,
    input logic [REG_AW-1:0] s
  );
    return t.valid && use_s && (s == t.dst);
  endfunction

  // Writes to the zero register never produce a valid tag.
  always_comb begin
    id_tag       = '0;
    id_tag.valid = id_valid && id_we && (id_dst != '0);
    id_tag.dst   = id_dst;
    id_tag.load  = id_load;
  end

  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;

  assign ex_a  = hit(ex_q,  id_use_rs, id_rs);
  assign ex_b  = hit(ex_q,  id_use_rt, id_rt);
  assign mem_a = hit(mem_q, id_use_rs, id_rs);
  assign mem_b = hit(mem_q, id_use_rt, id_rt);
  assign wb_a  = hit(wb_q,  id_use_rs, id_rs);
  assign wb_b  = hit(wb_q,  id_use_rt, id_rt);

  logic load_use;
  logic wb_haz;
  logic raw_haz;

  assign load_use = ex_q.load && (ex_a || ex_b);
  assign wb_haz   = !WB_BYPASS && (wb_a || wb_b);

`ifdef HAZ_FWD_EN
  assign raw_haz = load_use;
`else
  assign raw_haz = ex_a || ex_b || mem_a || mem_b;
`endif

  assign stall = id_valid && !flush
              && (raw_haz || load_use || wb_haz);

  assign ex_bubble = !(id_valid && !stall && !flush);

  pipe_tag_stage #(.W(TW)) u_ex (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (id_tag),
    .bubble (ex_bubble),
    .q      (ex_q)
  );

  pipe_tag_stage #(.W(TW)) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (ex_q),
    .bubble (1'b0),
    .q      (mem_q)
  );

  pipe_tag_stage #(.W(TW)) u_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (mem_q),
    .bubble (1'b0),
    .q      (wb_q)
  );

`ifdef HAZ_FWD_EN
  // Selects are consumed one cycle later, when producers have advanced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (ex_bubble) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else begin
      fwd_a_sel <= fwd_pick(ex_a, mem_a);
      fwd_b_sel <= fwd_pick(ex_b, mem_b);
    end
  end
`else
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

  logic unused_tag;
  assign unused_tag = ^{mem_q.load, wb_q.load};

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed vector bench for pipe_hazard_unit with WB_BYPASS = 0.
// Expected values follow the HAZ_FWD_EN setting of the build.
module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_use_rs, id_use_rt;
  logic        id_we, id_load, flush;
  logic        stall;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_unit #(
    .REG_AW    (5),
    .WB_BYPASS (1'b0),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_dst    (id_dst),
    .id_we     (id_we),
    .id_load   (id_load),
    .flush     (flush),
    .stall     (stall),
    .fwd_a_sel (fwd_a_sel),
    .fwd_b_sel (fwd_b_sel),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] dst;
    logic       we, ld, fl;
    logic       es;
    logic [1:0] ea, eb;
    int         ec;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  function automatic vec_t r(
    int v, int rs, int rt, int urs, int urt, int dst,
    int we, int ld, int fl, int es, int ea, int eb, int ec
  );
    vec_t t;
    t.v = v[0]; t.rs = 5'(rs); t.rt = 5'(rt);
    t.urs = urs[0]; t.urt = urt[0]; t.dst = 5'(dst);
    t.we = we[0]; t.ld = ld[0]; t.fl = fl[0];
    t.es = es[0]; t.ea = 2'(ea); t.eb = 2'(eb); t.ec = ec;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid  = t.v;
    id_rs     = t.rs;
    id_rt     = t.rt;
    id_use_rs = t.urs;
    id_use_rt = t.urt;
    id_dst    = t.dst;
    id_we     = t.we;
    id_load   = t.ld;
    flush     = t.fl;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    else
      n_pass++;
  endtask

  initial begin
`ifdef HAZ_FWD_EN
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(r(1,1,2,1,1,3,1,0,0, 0,0,0,0));
    tbl.push_back(r(1,3,5,1,1,4,1,0,0, 0,0,0,0));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(r(1,1,2,1,1,3,1,0,0, 0,0,0,0));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(r(1,3,3,1,1,6,1,0,0, 0,0,0,0));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,2,2,0));
    tbl.push_back(r(1,1,0,1,0,7,1,1,0, 0,0,0,0));
    tbl.push_back(r(1,7,7,1,1,8,1,0,0, 1,0,0,0));
    tbl.push_back(r(1,7,7,1,1,8,1,0,0, 0,0,0,1));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,2,2,1));
    tbl.push_back(r(1,1,2,1,1,0,1,0,0, 0,0,0,1));
    tbl.push_back(r(1,0,0,1,1,5,1,0,0, 0,0,0,1));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,1));
    tbl.push_back(r(1,1,0,1,0,9,1,1,0, 0,0,0,1));
    tbl.push_back(r(1,9,9,1,1,10,1,0,1, 0,0,0,1));
    tbl.push_back(r(1,10,10,1,1,11,1,0,0, 0,0,0,1));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,1));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,1));
    tbl.push_back(r(1,11,1,1,1,12,1,0,0, 1,0,0,1));
    tbl.push_back(r(1,11,1,1,1,12,1,0,0, 0,0,0,2));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,2));
`else
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tbl.push_back(r(1,1,2,1,1,3,1,0,0, 0,0,0,0));
    tbl.push_back(r(1,3,5,1,1,4,1,0,0, 1,0,0,0));
    tbl.push_back(r(1,3,5,1,1,4,1,0,0, 1,0,0,1));
    tbl.push_back(r(1,3,5,1,1,4,1,0,0, 1,0,0,2));
    tbl.push_back(r(1,3,5,1,1,4,1,0,0, 0,0,0,3));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,3));
    tbl.push_back(r(1,1,0,1,0,7,1,1,0, 0,0,0,3));
    tbl.push_back(r(1,7,7,1,1,8,1,0,0, 1,0,0,3));
    tbl.push_back(r(1,7,7,1,1,8,1,0,0, 1,0,0,4));
    tbl.push_back(r(1,7,7,1,1,8,1,0,0, 1,0,0,5));
    tbl.push_back(r(1,7,7,1,1,8,1,0,0, 0,0,0,6));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,6));
    tbl.push_back(r(1,1,2,1,1,0,1,0,0, 0,0,0,6));
    tbl.push_back(r(1,0,0,1,1,5,1,0,0, 0,0,0,6));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,6));
    tbl.push_back(r(1,1,0,1,0,9,1,1,0, 0,0,0,6));
    tbl.push_back(r(1,9,9,1,1,10,1,0,1, 0,0,0,6));
    tbl.push_back(r(1,10,10,1,1,11,1,0,0, 0,0,0,6));
    tbl.push_back(r(0,0,0,0,0,0,0,0,0, 0,0,0,6));
`endif

    rst_n = 1'b0;
    drive(r(0,0,0,0,0,0,0,0,0, 0,0,0,0));
    #2;
    chk("reset stall", 32'(stall), 0);
    chk("reset fwd_a", 32'(fwd_a_sel), 0);
    chk("reset fwd_b", 32'(fwd_b_sel), 0);
    chk("reset cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      chk($sformatf("row%0d stall", i), 32'(stall), 32'(tbl[i].es));
      chk($sformatf("row%0d fwd_a", i), 32'(fwd_a_sel), 32'(tbl[i].ea));
      chk($sformatf("row%0d fwd_b", i), 32'(fwd_b_sel), 32'(tbl[i].eb));
      chk($sformatf("row%0d cnt", i), 32'(stall_cnt), 32'(tbl[i].ec));
    end

    // Load-use stall interrupted by an asynchronous reset.
    @(negedge clk);
    drive(r(1,1,0,1,0,7,1,1,0, 0,0,0,0));
    @(negedge clk);
    drive(r(1,7,7,1,1,8,1,0,0, 0,0,0,0));
    #2;
    chk("midrst pre stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst stall", 32'(stall), 0);
    chk("midrst fwd_a", 32'(fwd_a_sel), 0);
    chk("midrst fwd_b", 32'(fwd_b_sel), 0);
    chk("midrst cnt", 32'(stall_cnt), 0);
    @(negedge clk);
    drive(r(0,0,0,0,0,0,0,0,0, 0,0,0,0));
    rst_n = 1'b1;
    @(negedge clk);
    drive(r(1,7,7,1,1,8,1,0,0, 0,0,0,0));
    #2;
    chk("post rst stall", 32'(stall), 0);
    chk("post rst cnt", 32'(stall_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
